// File: rtl/komut_yukleyici.sv
// Byte-serial program loader and zero-latency instruction ROM port for a small core.
// Optional feature macro: KOMUT_YUKLEYICI_CHECKSUM_EN (trailing XOR checksum byte).
module komut_yukleyici #(
    parameter int          DERINLIK  = 64,
    parameter logic [31:0] NOP_KOMUT = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  yukle_veri,
    input  logic        yukle_gecerli,
    input  logic        yukle_son,
    output logic        yukle_hazir,
    input  logic        yeniden_yukle,
    input  logic [31:0] pc_islemci,
    output logic [31:0] komut_islemci,
    output logic        islemci_calis,
    output logic        hata
);

    localparam int AW = (DERINLIK > 1) ? $clog2(DERINLIK) : 1;
    localparam int KW = $clog2(DERINLIK + 1);
    localparam logic [KW-1:0] SINIR = KW'(DERINLIK);

    typedef enum logic [2:0] {
        BOS     = 3'd0,
        YUKLE   = 3'd1,
        CALIS   = 3'd2,
`ifdef KOMUT_YUKLEYICI_CHECKSUM_EN
        SAGLAMA = 3'd4,
`endif
        HATA    = 3'd3
    } durum_t;

    durum_t          r_durum;
    durum_t          w_sonraki;
    logic [1:0]      r_bayt_sayac;
    logic [KW-1:0]   r_kelime_sayac;
    logic [23:0]     r_kelime;
    logic            r_hata;
    logic [31:0]     r_mem [0:DERINLIK-1];
`ifdef KOMUT_YUKLEYICI_CHECKSUM_EN
    logic [7:0]      r_saglama;
`endif

    logic            w_kabul;
    logic            w_yukleme;
    logic            w_tasma;
    logic            w_yaz;
    logic            w_temizle;
    logic            w_getir_hata;
    logic            w_hizali;
    logic            w_aralik;
    logic [29:0]     w_pc_kelime;

    assign w_pc_kelime = pc_islemci[31:2];
    assign w_hizali    = (pc_islemci[1:0] == 2'b00);
    assign w_aralik    = (w_pc_kelime < {{(30-KW){1'b0}}, r_kelime_sayac});
    assign w_yukleme   = (r_durum == BOS) || (r_durum == YUKLE);
    assign w_kabul     = yukle_gecerli && yukle_hazir;
    assign w_tasma     = (r_kelime_sayac == SINIR);

    assign islemci_calis = (r_durum == CALIS);
    assign hata          = r_hata;
`ifdef KOMUT_YUKLEYICI_CHECKSUM_EN
    assign yukle_hazir   = w_yukleme || (r_durum == SAGLAMA);
`else
    assign yukle_hazir   = w_yukleme;
`endif

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_durum <= BOS;
        end else begin
            r_durum <= w_sonraki;
        end
    end

    // Next-state logic plus write, clear and fetch-error strobes
    always_comb begin
        w_sonraki    = r_durum;
        w_yaz        = 1'b0;
        w_temizle    = 1'b0;
        w_getir_hata = 1'b0;
        case (r_durum)
            BOS, YUKLE: begin
                if (w_kabul) begin
                    if (w_tasma) begin
                        w_sonraki = HATA;
                    end else if (r_bayt_sayac == 2'd3) begin
                        w_yaz = 1'b1;
                        if (yukle_son) begin
`ifdef KOMUT_YUKLEYICI_CHECKSUM_EN
                            w_sonraki = SAGLAMA;
`else
                            w_sonraki = CALIS;
`endif
                        end else begin
                            w_sonraki = YUKLE;
                        end
                    end else if (yukle_son) begin
                        w_sonraki = HATA;
                    end else begin
                        w_sonraki = YUKLE;
                    end
                end else begin
                    w_sonraki = r_durum;
                end
            end
`ifdef KOMUT_YUKLEYICI_CHECKSUM_EN
            SAGLAMA: begin
                if (w_kabul) begin
                    w_sonraki = (yukle_veri == r_saglama) ? CALIS : HATA;
                end else begin
                    w_sonraki = SAGLAMA;
                end
            end
`endif
            CALIS: begin
                // A reload request outranks a bad fetch on the same cycle
                if (yeniden_yukle) begin
                    w_sonraki = BOS;
                    w_temizle = 1'b1;
                end else if (!w_hizali || !w_aralik) begin
                    w_getir_hata = 1'b1;
                end else begin
                    w_sonraki = CALIS;
                end
            end
            HATA: begin
                if (yeniden_yukle) begin
                    w_sonraki = BOS;
                    w_temizle = 1'b1;
                end else begin
                    w_sonraki = HATA;
                end
            end
            default: begin
                w_sonraki = BOS;
            end
        endcase
    end

    // Byte assembly, word counter, sticky error and running checksum
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_bayt_sayac   <= 2'd0;
            r_kelime_sayac <= {KW{1'b0}};
            r_kelime       <= 24'd0;
            r_hata         <= 1'b0;
`ifdef KOMUT_YUKLEYICI_CHECKSUM_EN
            r_saglama      <= 8'd0;
`endif
        end else if (w_temizle) begin
            r_bayt_sayac   <= 2'd0;
            r_kelime_sayac <= {KW{1'b0}};
            r_hata         <= 1'b0;
`ifdef KOMUT_YUKLEYICI_CHECKSUM_EN
            r_saglama      <= 8'd0;
`endif
        end else begin
            if (w_kabul && w_yukleme && !w_tasma) begin
                r_bayt_sayac <= r_bayt_sayac + 2'd1;
                case (r_bayt_sayac)
                    2'd0:    r_kelime[7:0]   <= yukle_veri;
                    2'd1:    r_kelime[15:8]  <= yukle_veri;
                    2'd2:    r_kelime[23:16] <= yukle_veri;
                    default: r_kelime        <= r_kelime;
                endcase
                if (w_yaz) begin
                    r_kelime_sayac <= r_kelime_sayac + KW'(1);
                end
`ifdef KOMUT_YUKLEYICI_CHECKSUM_EN
                r_saglama <= r_saglama ^ yukle_veri;
`endif
            end
            if ((w_sonraki == HATA) || w_getir_hata) begin
                r_hata <= 1'b1;
            end
        end
    end

    // Program memory: deliberately not reset so contents survive reset and reload
    always_ff @(posedge clk) begin
        if (!reset && w_yaz) begin
            r_mem[r_kelime_sayac[AW-1:0]] <= {yukle_veri, r_kelime};
        end
    end

    // Combinational fetch; anything not cleanly loaded reads as NOP
    always_comb begin
        komut_islemci = NOP_KOMUT;
        if ((r_durum == CALIS) && w_hizali && w_aralik) begin
            komut_islemci = r_mem[w_pc_kelime[AW-1:0]];
        end else begin
            komut_islemci = NOP_KOMUT;
        end
    end

endmodule

// File: tb/tb_komut_yukleyici.sv
// Directed bench for komut_yukleyici: load, fetch, error, overflow, reset and reload paths.
module tb_komut_yukleyici;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  yukle_veri;
    logic        yukle_gecerli;
    logic        yukle_son;
    logic        yukle_hazir;
    logic        yeniden_yukle;
    logic [31:0] pc_islemci;
    logic [31:0] komut_islemci;
    logic        islemci_calis;
    logic        hata;

    int          n_kontrol = 0;
    int          n_hata    = 0;
    logic [7:0]  tb_xor    = 8'd0;

    komut_yukleyici #(.DERINLIK(64), .NOP_KOMUT(NOP)) dut (
        .clk           (clk),
        .reset         (reset),
        .yukle_veri    (yukle_veri),
        .yukle_gecerli (yukle_gecerli),
        .yukle_son     (yukle_son),
        .yukle_hazir   (yukle_hazir),
        .yeniden_yukle (yeniden_yukle),
        .pc_islemci    (pc_islemci),
        .komut_islemci (komut_islemci),
        .islemci_calis (islemci_calis),
        .hata          (hata)
    );

    always #5 clk = ~clk;

    task automatic kontrol(input string etiket, input logic [31:0] gozlenen, input logic [31:0] beklenen);
        n_kontrol++;
        if (gozlenen !== beklenen) begin
            n_hata++;
            $display("FAIL %s: got %h expected %h", etiket, gozlenen, beklenen);
        end
    endtask

    task automatic bayt_gonder(input logic [7:0] b, input logic son);
        yukle_veri    = b;
        yukle_gecerli = 1'b1;
        yukle_son     = son;
        tb_xor        = tb_xor ^ b;
        @(posedge clk);
        #1;
        yukle_gecerli = 1'b0;
        yukle_son     = 1'b0;
    endtask

    task automatic kelime_gonder(input logic [31:0] w, input logic son);
        bayt_gonder(w[7:0],   1'b0);
        bayt_gonder(w[15:8],  1'b0);
        bayt_gonder(w[23:16], 1'b0);
        bayt_gonder(w[31:24], son);
    endtask

    task automatic yukleme_bitir();
`ifdef KOMUT_YUKLEYICI_CHECKSUM_EN
        logic [7:0] c;
        c = tb_xor;
        bayt_gonder(c, 1'b0);
`endif
    endtask

    task automatic yeniden();
        yeniden_yukle = 1'b1;
        @(posedge clk);
        #1;
        yeniden_yukle = 1'b0;
        tb_xor        = 8'd0;
    endtask

    task automatic durum_kontrol(input string etiket, input logic hz, input logic cl, input logic ht);
        kontrol({etiket, ".hazir"}, 32'(yukle_hazir),   32'(hz));
        kontrol({etiket, ".calis"}, 32'(islemci_calis), 32'(cl));
        kontrol({etiket, ".hata"},  32'(hata),          32'(ht));
    endtask

    initial begin
        reset         = 1'b1;
        yukle_veri    = 8'd0;
        yukle_gecerli = 1'b0;
        yukle_son     = 1'b0;
        yeniden_yukle = 1'b0;
        pc_islemci    = 32'd0;
        #2;
        durum_kontrol("reset", 1'b1, 1'b0, 1'b0);
        kontrol("reset.komut", komut_islemci, NOP);
        #10;
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Two-word program, last byte on byte 8
        tb_xor = 8'd0;
        kelime_gonder(32'h0000_0013, 1'b0);
        kontrol("ld1.calis_early", 32'(islemci_calis), 32'd0);
        kelime_gonder(32'h0010_0093, 1'b1);
        yukleme_bitir();
        durum_kontrol("ld1", 1'b0, 1'b1, 1'b0);
        pc_islemci = 32'd0;
        #1 kontrol("ld1.pc0", komut_islemci, 32'h0000_0013);
        pc_islemci = 32'd4;
        #1 kontrol("ld1.pc4", komut_islemci, 32'h0010_0093);
        pc_islemci = 32'd8;
        #1 kontrol("ld1.pc8", komut_islemci, NOP);
        kontrol("ld1.hata_pre", 32'(hata), 32'd0);
        @(posedge clk);
        #1;
        durum_kontrol("ld1.range", 1'b0, 1'b1, 1'b1);
        pc_islemci = 32'd0;
        yeniden();
        durum_kontrol("reload1", 1'b1, 1'b0, 1'b0);
        kontrol("reload1.komut", komut_islemci, NOP);

        // Misaligned fetch
        kelime_gonder(32'hAABB_CCDD, 1'b0);
        kelime_gonder(32'h1122_3344, 1'b1);
        yukleme_bitir();
        pc_islemci = 32'd2;
        #1 kontrol("mis.pc2", komut_islemci, NOP);
        @(posedge clk);
        #1;
        durum_kontrol("mis", 1'b0, 1'b1, 1'b1);
        pc_islemci = 32'd4;
        #1 kontrol("mis.pc4", komut_islemci, 32'h1122_3344);
        pc_islemci = 32'd0;
        yeniden();

        // Last flag mid-word
        for (int i = 0; i < 6; i++) begin
            bayt_gonder(8'(i + 1), i == 5);
        end
        durum_kontrol("short", 1'b0, 1'b0, 1'b1);
        yeniden();
        durum_kontrol("reload2", 1'b1, 1'b0, 1'b0);

        // Full 64-word program
        for (int i = 0; i < 64; i++) begin
            kelime_gonder({8'hC0, 8'h00, 8'(i), 8'h33}, i == 63);
        end
        yukleme_bitir();
        durum_kontrol("full", 1'b0, 1'b1, 1'b0);
        pc_islemci = 32'd252;
        #1 kontrol("full.pc252", komut_islemci, 32'hC000_3F33);
        pc_islemci = 32'd256;
        #1 kontrol("full.pc256", komut_islemci, NOP);
        pc_islemci = 32'd0;
        yeniden();

        // Overflow on byte 257
        for (int i = 0; i < 64; i++) begin
            kelime_gonder({8'h5A, 8'h00, 8'(i), 8'hA5}, 1'b0);
        end
        durum_kontrol("ovf.256", 1'b1, 1'b0, 1'b0);
        bayt_gonder(8'h77, 1'b0);
        durum_kontrol("ovf.257", 1'b0, 1'b0, 1'b1);
        yeniden();

        // Reload request ignored while loading
        bayt_gonder(8'hEF, 1'b0);
        bayt_gonder(8'hBE, 1'b0);
        yeniden();
        kontrol("ign.hazir", 32'(yukle_hazir), 32'd1);
        bayt_gonder(8'hAD, 1'b0);
        bayt_gonder(8'hDE, 1'b1);
        yukleme_bitir();
        kontrol("ign.calis", 32'(islemci_calis), 32'd1);
        #1 kontrol("ign.pc0", komut_islemci, 32'hDEAD_BEEF);

        // Asynchronous reset while running
        #3 reset = 1'b1;
        #1;
        durum_kontrol("rst_run", 1'b1, 1'b0, 1'b0);
        kontrol("rst_run.komut", komut_islemci, NOP);
        #1 reset = 1'b0;
        @(posedge clk);
        #1;

        // Asynchronous reset mid-word, then a fresh single-word load
        tb_xor = 8'd0;
        bayt_gonder(8'h99, 1'b0);
        bayt_gonder(8'h88, 1'b0);
        #3 reset = 1'b1;
        #1;
        durum_kontrol("rst_mid", 1'b1, 1'b0, 1'b0);
        #1 reset = 1'b0;
        @(posedge clk);
        #1;
        tb_xor = 8'd0;
        kelime_gonder(32'h1234_5678, 1'b1);
        yukleme_bitir();
        kontrol("rst_mid.calis", 32'(islemci_calis), 32'd1);
        #1 kontrol("rst_mid.pc0", komut_islemci, 32'h1234_5678);
        pc_islemci = 32'd4;
        #1 kontrol("rst_mid.pc4", komut_islemci, NOP);
        pc_islemci = 32'd0;
        yeniden();

`ifdef KOMUT_YUKLEYICI_CHECKSUM_EN
        kelime_gonder(32'h0403_0201, 1'b1);
        kontrol("cs.wait", 32'(islemci_calis), 32'd0);
        bayt_gonder(8'h04, 1'b0);
        durum_kontrol("cs.ok", 1'b0, 1'b1, 1'b0);
        #1 kontrol("cs.pc0", komut_islemci, 32'h0403_0201);
        yeniden();
        kelime_gonder(32'h0403_0201, 1'b1);
        bayt_gonder(8'h05, 1'b0);
        durum_kontrol("cs.bad", 1'b0, 1'b0, 1'b1);
        yeniden();
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_kontrol, n_hata);
        $finish;
    end

endmodule
